rr_arbiter_4: RTL and testbench
===============================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive grant cycles per owner when timeout is compiled in (range 2..255).
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: req  input  4  request per requester; bit i = requester i.
REQ-005 Port: gnt  output  4  one-hot grant; all-zero when no owner.
REQ-006 Port: gnt_id  output  2  binary index of current owner; feeds 2x4 decoder select.
REQ-007 Port: gnt_vld  output  1  high while an owner holds the grant; feeds 2x4 decoder enable.
REQ-008 Port: timeout  output  1  one-cycle pulse when a grant is forcibly revoked.
REQ-009 The design SHALL use one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-010 All outputs SHALL be registered; gnt SHALL always equal the 2x4 decode of gnt_id gated by gnt_vld.
REQ-011 FSM states SHALL be IDLE and GRANT.
REQ-012 IDLE: if req != 0 at a clk edge, the block SHALL select an owner and enter GRANT, with gnt/gnt_id/gnt_vld valid after that same edge (1-cycle latency).
REQ-013 IDLE with req == 0: remain in IDLE, gnt = 0, gnt_vld = 0.
REQ-014 Selection SHALL be round-robin: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); first set req bit wins.
REQ-015 On each grant to requester i, ptr SHALL update to (i+1) mod 4 (wrap 3 -> 0).
REQ-016 GRANT: owner holds while req[gnt_id] = 1; requests from other requesters SHALL be ignored (no preemption).
REQ-017 GRANT: req[gnt_id] = 0 at an edge -> release: gnt = 0, gnt_vld = 0, return to IDLE after that edge.
REQ-018 Between two grants there SHALL be at least one cycle with gnt_vld = 0 (IDLE arbitration cycle).
REQ-019 Owner drop simultaneous with new requests: release first; new requests arbitrated at the following edge.
REQ-020 gnt_id SHALL hold its last value while gnt_vld = 0.
REQ-021 timeout SHALL be 0 except as defined in REQ-027.

Reset
REQ-022 rst_n low SHALL immediately, regardless of clk, force state = IDLE, ptr = 0, gnt = 0, gnt_id = 0, gnt_vld = 0, timeout = 0, hold counter = 0.
REQ-023 Reset asserted mid-grant SHALL drop the grant with no timeout pulse; the first arbitration after release starts from ptr = 0.
REQ-024 Deassertion of rst_n SHALL take effect at the first subsequent clk rising edge.

Configuration
REQ-025 Macro RR_ARBITER_4_TIMEOUT_EN SHALL compile the grant-hold timeout in or out.
REQ-026 Defined: a hold counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-027 Defined: when the owner has held for MAX_HOLD cycles and still requests, the grant SHALL be revoked at the next edge, timeout pulses high for exactly one cycle, state -> IDLE; ptr is already past the revoked owner.
REQ-028 Not defined: no hold counter is present, grants are held indefinitely, and timeout SHALL be tied 0.

Verification
REQ-029 Reset then req=4'b0001 -> after next edge gnt=4'b0001, gnt_id=0, gnt_vld=1; drop req -> gnt=0 next edge.
REQ-030 req=4'b1111 held, each owner drops after 2 cycles and re-requests -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-031 ptr=3, req=4'b1001 -> grant to 3, then ptr=0 and 0 granted next (wrap-around).
REQ-032 Owner 1 holding, req[2] rises -> gnt stays 4'b0010 until req[1] falls; then gnt=4'b0100 two edges later.
REQ-033 With RR_ARBITER_4_TIMEOUT_EN, MAX_HOLD=8, req=4'b0011 held -> requester 0 granted 8 cycles, timeout=1 one cycle, then requester 1 granted; without macro requester 0 holds forever, timeout=0.
REQ-034 rst_n pulsed low between clk edges during grant to requester 2 -> gnt=0 and gnt_vld=0 immediately, no timeout pulse; after release req=4'b0101 -> requester 0 granted.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with registered one-hot grant.
// An owner keeps the grant for as long as it requests; there is no preemption, and
// every release is followed by at least one idle arbitration cycle.
// Optional grant-hold timeout is enabled with `define RR_ARBITER_4_TIMEOUT_EN: when an
// owner has held for MAX_HOLD cycles and still requests, its grant is revoked and
// timeout pulses for one cycle.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [1:0] ptr;
    logic [1:0] ptr_n;
    logic [1:0] gnt_id_n;
    logic       gnt_vld_n;
    logic       timeout_n;
    logic [3:0] gnt_n;

    logic       found;
    logic [1:0] pick;
    logic [1:0] idx;

`ifdef RR_ARBITER_4_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_n;
`endif

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_4: MAX_HOLD must be in 2..255");
    end

    // Round-robin search: first requester at or after ptr (mod 4) wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + k[1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next-state and next-output logic; gnt is always the gated decode of gnt_id.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gnt_id_n  = gnt_id;
        gnt_vld_n = gnt_vld;
        timeout_n = 1'b0;
`ifdef RR_ARBITER_4_TIMEOUT_EN
        hold_cnt_n = hold_cnt;
`endif
        case (state)
            IDLE: begin
                gnt_vld_n = 1'b0;
                if (found) begin
                    state_n   = GRANT;
                    ptr_n     = pick + 2'd1;
                    gnt_id_n  = pick;
                    gnt_vld_n = 1'b1;
`ifdef RR_ARBITER_4_TIMEOUT_EN
                    hold_cnt_n = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    state_n   = IDLE;
                    gnt_vld_n = 1'b0;
                end
`ifdef RR_ARBITER_4_TIMEOUT_EN
                else if (hold_cnt == HOLD_LAST) begin
                    state_n   = IDLE;
                    gnt_vld_n = 1'b0;
                    timeout_n = 1'b1;
                end else begin
                    hold_cnt_n = hold_cnt + 8'd1;
                end
`endif
            end
            default: begin
                state_n   = IDLE;
                gnt_vld_n = 1'b0;
            end
        endcase
        gnt_n = gnt_vld_n ? (4'b0001 << gnt_id_n) : '0;
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
`ifdef RR_ARBITER_4_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
            gnt_vld <= gnt_vld_n;
            timeout <= timeout_n;
`ifdef RR_ARBITER_4_TIMEOUT_EN
            hold_cnt <= hold_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4 against a behavioural round-robin model.
// Honours `define RR_ARBITER_4_TIMEOUT_EN the same way the design does.
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 8;
`ifdef RR_ARBITER_4_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    // Behavioural model: current owner (-1 = none), pointer, last id, cycles held.
    int m_owner;
    int m_ptr;
    int m_last_id;
    int m_hold;
    bit m_to;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_last_id = 0;
        m_hold    = 0;
        m_to      = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] r);
        int c;
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (m_owner < 0 && r[c]) begin
                    m_owner   = c;
                    m_last_id = c;
                    m_ptr     = (c + 1) % 4;
                    m_hold    = 1;
                end
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (TO_EN && m_hold >= MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_hold = m_hold + 1;
        end
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        logic [1:0] id;
        g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        id = m_last_id[1:0];
        return {g, id, (m_owner >= 0), m_to};
    endfunction

    // Drive req, advance one clock edge, update model, settle for sampling.
    task automatic tick(input logic [3:0] r);
        req = r;
        @(posedge clk);
        if (rst_n) model_step(r);
        else model_reset();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({gnt, gnt_id, gnt_vld, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", {gnt, gnt_id, gnt_vld, timeout}, 8'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        logic [3:0] pat [2];
        pat[0] = 4'b0001;
        pat[1] = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick(pat[i]);
            checks++;
            if ({gnt, gnt_id, gnt_vld, timeout} !== exp_vec()) begin
                errors++;
                $display("FAIL single step%0d: got %b expected %b", i, {gnt, gnt_id, gnt_vld, timeout}, exp_vec());
            end
        end
    endtask

    task automatic test_rotation();
        int order [5];
        int n;
        int cyc;
        logic [3:0] r;
        logic prev_vld;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        do_reset();
        n = 0;
        cyc = 0;
        prev_vld = 1'b0;
        while (n < 5 && cyc < 40) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_hold == 2) r[m_owner] = 1'b0;
            tick(r);
            cyc++;
            checks++;
            if ({gnt, gnt_id, gnt_vld, timeout} !== exp_vec()) begin
                errors++;
                $display("FAIL rotation cyc%0d: got %b expected %b", cyc, {gnt, gnt_id, gnt_vld, timeout}, exp_vec());
            end
            if (gnt_vld && !prev_vld) begin
                checks++;
                if (int'(gnt_id) != order[n]) begin
                    errors++;
                    $display("FAIL rotation_order grant%0d: got id %0d expected %0d", n, gnt_id, order[n]);
                end
                n++;
            end
            prev_vld = gnt_vld;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rotation_budget: got %0d grants expected 5", n);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] pat [5];
        logic [1:0] ids [5];
        logic       vlds [5];
        pat[0] = 4'b0100; ids[0] = 2'd2; vlds[0] = 1'b1;
        pat[1] = 4'b0000; ids[1] = 2'd2; vlds[1] = 1'b0;
        pat[2] = 4'b1001; ids[2] = 2'd3; vlds[2] = 1'b1;
        pat[3] = 4'b0001; ids[3] = 2'd3; vlds[3] = 1'b0;
        pat[4] = 4'b0001; ids[4] = 2'd0; vlds[4] = 1'b1;
        tick(4'b0000);
        for (int i = 0; i < 5; i++) begin
            tick(pat[i]);
            checks++;
            if ({gnt, gnt_id, gnt_vld, timeout} !== exp_vec() || gnt_id !== ids[i] || gnt_vld !== vlds[i]) begin
                errors++;
                $display("FAIL wrap step%0d: got %b expected %b (id %0d vld %b)", i, {gnt, gnt_id, gnt_vld, timeout}, exp_vec(), ids[i], vlds[i]);
            end
        end
    endtask

    task automatic test_no_preempt();
        logic [3:0] pat [7];
        logic [3:0] g [7];
        pat[0] = 4'b0000; g[0] = 4'b0000;
        pat[1] = 4'b0010; g[1] = 4'b0010;
        pat[2] = 4'b0110; g[2] = 4'b0010;
        pat[3] = 4'b0110; g[3] = 4'b0010;
        pat[4] = 4'b0110; g[4] = 4'b0010;
        pat[5] = 4'b0100; g[5] = 4'b0000;
        pat[6] = 4'b0100; g[6] = 4'b0100;
        for (int i = 0; i < 7; i++) begin
            tick(pat[i]);
            checks++;
            if ({gnt, gnt_id, gnt_vld, timeout} !== exp_vec() || gnt !== g[i]) begin
                errors++;
                $display("FAIL no_preempt step%0d: got %b expected %b (gnt %b)", i, {gnt, gnt_id, gnt_vld, timeout}, exp_vec(), g[i]);
            end
        end
        tick(4'b0000);
    endtask

    task automatic test_timeout();
        int first_run;
        int pulses;
        bit in_first;
        do_reset();
        first_run = 0;
        pulses    = 0;
        in_first  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(4'b0011);
            checks++;
            if ({gnt, gnt_id, gnt_vld, timeout} !== exp_vec()) begin
                errors++;
                $display("FAIL timeout cyc%0d: got %b expected %b", i, {gnt, gnt_id, gnt_vld, timeout}, exp_vec());
            end
            if (in_first && gnt == 4'b0001) first_run++;
            else in_first = 1'b0;
            if (timeout) pulses++;
        end
        checks++;
        if (first_run != (TO_EN ? MAX_HOLD : 20)) begin
            errors++;
            $display("FAIL timeout_hold_len: got %0d expected %0d", first_run, TO_EN ? MAX_HOLD : 20);
        end
        checks++;
        if (pulses != (TO_EN ? 2 : 0)) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d expected %0d", pulses, TO_EN ? 2 : 0);
        end
        tick(4'b0000);
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(4'b0100);
        checks++;
        if (gnt !== 4'b0100 || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got gnt %b vld %b expected 0100 1", gnt, gnt_vld);
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({gnt, gnt_id, gnt_vld, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL async_immediate: got %b expected %b", {gnt, gnt_id, gnt_vld, timeout}, 8'b0);
        end
        tick(4'b0101);
        checks++;
        if ({gnt, gnt_id, gnt_vld, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL async_held: got %b expected %b", {gnt, gnt_id, gnt_vld, timeout}, 8'b0);
        end
        #3;
        rst_n = 1'b1;
        tick(4'b0101);
        checks++;
        if ({gnt, gnt_id, gnt_vld, timeout} !== exp_vec() || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL async_after: got %b expected %b", {gnt, gnt_id, gnt_vld, timeout}, exp_vec());
        end
        tick(4'b0000);
    endtask

    task automatic test_random();
        logic [3:0] r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom);
            if (m_owner >= 0 && ($urandom % 5) != 0) r[m_owner] = 1'b1;
            tick(r);
            checks++;
            if ({gnt, gnt_id, gnt_vld, timeout} !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d req=%b: got %b expected %b", i, r, {gnt, gnt_id, gnt_vld, timeout}, exp_vec());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_no_preempt();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
